mem_access_unit: RTL and testbench

//  MEM-stage consumer of the EXE/MEM pipeline register fields: turns a load/store into one

---
 rtl/mau_pkg.sv | 35 +++
 rtl/mau_load_ext.sv | 41 ++++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the MEM-stage access unit.
//   LD_* codes   : EXE/MEM load_type encoding (LD_NONE means "not a load")
//   state_e      : access FSM states (exposed on the top's dbg_state port)
//   LANES        : byte lanes on the 32-bit data bus
//   be_count()   : number of enabled byte lanes, used to size a store
package mau_pkg;

  localparam int BUS_DW = 32;
  localparam int LANES  = BUS_DW / 8;

  localparam logic [3:0] LD_NONE = 4'd0;
  localparam logic [3:0] LD_LB   = 4'd1;
  localparam logic [3:0] LD_LBU  = 4'd2;
  localparam logic [3:0] LD_LH   = 4'd3;
  localparam logic [3:0] LD_LHU  = 4'd4;
  localparam logic [3:0] LD_LW   = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_e;

  function automatic logic [2:0] be_count(input logic [LANES-1:0] be);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {2'b00, be[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mau_load_ext.sv
// mau_load_ext: combinational load data alignment and extension.
//   load_type in  4   LD_* code; LD_NONE yields zero
//   addr_lo   in  2   effective address bits [1:0]
//   rdata     in  32  raw bus read word
//   result    out 32  selected byte/half/word, sign- or zero-extended
module mau_load_ext
  import mau_pkg::*;
(
  input  logic [3:0]        load_type,
  input  logic [1:0]        addr_lo,
  input  logic [BUS_DW-1:0] rdata,
  output logic [BUS_DW-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword lane is picked by addr[1] only; addr[0] is ignored here.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    result = '0;
    case (load_type)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'd0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'd0, half_sel};
      LD_LW:   result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer. Converts the instruction held in
// the EXE/MEM register into one sram-like bus transaction, stalls EXE/MEM until the
// response arrives and returns the aligned, extended load data for MEM/WB.
//
// Ports
//   clk, rst (async, active-high)
//   mem_wmem, mem_load_type, mem_byte_valid, mem_addr, mem_wdata, mem_exc : EXE/MEM fields
//   mem_advance : EXE/MEM loads a new instruction this edge
//   flush       : kill the current access (irq or pipeline clear)
//   data_req/wr/be/addr/wdata, data_addr_ok, data_data_ok, data_rdata : data bus
//   mem_stall   : hold EXE/MEM
//   load_result : extended load data
//   adel, ades  : misaligned load / store (only with MEM_ALIGN_CHECK_EN)
//   dbg_state   : current FSM state
//
// Build option: MEM_ALIGN_CHECK_EN adds the alignment check and the adel/ades ports.
//
// Bus handshake: a request is presented while data_req is high and is accepted in the
// cycle data_addr_ok is high; address, byte enables and write data stay stable until
// then. Exactly one data_data_ok follows each accepted request, possibly in the same
// cycle as data_addr_ok; data_rdata is valid only with data_data_ok.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_wmem,
  input  logic [3:0]       mem_load_type,
  input  logic [LANES-1:0] mem_byte_valid,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_wdata,
  input  logic             mem_exc,
  input  logic             mem_advance,
  input  logic             flush,
  output logic             data_req,
  output logic             data_wr,
  output logic [LANES-1:0] data_be,
  output logic [AW-1:0]    data_addr,
  output logic [DW-1:0]    data_wdata,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  input  logic [DW-1:0]    data_rdata,
  output logic             mem_stall,
`ifdef MEM_ALIGN_CHECK_EN
  output logic             adel,
  output logic             ades,
`endif
  output logic [DW-1:0]    load_result,
  output state_e           dbg_state
);

  state_e        state;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] ext_data;
  logic          is_load;
  logic          misaligned;
  logic          access;
  logic          issue;
  logic          accepted;
  logic          resp_ok;

  mau_load_ext u_load_ext (
    .load_type (mem_load_type),
    .addr_lo   (mem_addr[1:0]),
    .rdata     (data_rdata),
    .result    (ext_data)
  );

  assign is_load = (mem_load_type != LD_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  logic is_half;
  logic is_word;

  // Store width is recovered from the number of enabled lanes.
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (mem_wmem) begin
      is_half = (be_count(mem_byte_valid) == 3'd2);
      is_word = (be_count(mem_byte_valid) == 3'd4);
    end else begin
      is_half = (mem_load_type == LD_LH) || (mem_load_type == LD_LHU);
      is_word = (mem_load_type == LD_LW);
    end
    misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
  end

  assign adel = is_load  & misaligned & ~mem_exc & ~flush;
  assign ades = mem_wmem & misaligned & ~mem_exc & ~flush;
`else
  assign misaligned = 1'b0;
`endif

  assign access   = (mem_wmem | is_load) & ~mem_exc & ~flush & ~misaligned;
  // A request is only driven from IDLE or REQ; flush drops it in the same cycle.
  assign issue    = access & ((state == ST_IDLE) | (state == ST_REQ));
  assign accepted = issue & data_addr_ok;
  // data_ok belongs to this instruction in WAIT or when it arrives with acceptance.
  assign resp_ok  = data_data_ok & ((state == ST_WAIT) | accepted);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_REQ: begin
          if (accepted) begin
            if (data_data_ok) begin
              rdata_q <= ext_data;
              // If EXE/MEM moves on in the response cycle there is nothing to hold.
              state   <= mem_advance ? ST_IDLE : ST_DONE;
            end else begin
              state <= ST_WAIT;
            end
          end else if (issue) begin
            state <= ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            rdata_q <= ext_data;
            state   <= (mem_advance || flush) ? ST_IDLE : ST_DONE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (mem_advance || flush) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          // The killed request still owes a response; swallow it.
          if (data_data_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_req    = issue;
  assign data_wr     = issue & mem_wmem;
  assign data_be     = issue ? (mem_wmem ? mem_byte_valid : {LANES{1'b1}}) : '0;
  assign data_addr   = issue ? {mem_addr[AW-1:2], 2'b00} : '0;
  assign data_wdata  = (issue & mem_wmem) ? mem_wdata : '0;

  assign mem_stall   = (access & (state != ST_DONE) & ~data_data_ok) | (state == ST_DRAIN);
  assign load_result = resp_ok ? ext_data : ((state == ST_DONE) ? rdata_q : '0);
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam int K_NOP = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4, K_LW = 5,
                 K_SB = 6, K_SH = 7, K_SW = 8;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
  logic adel, ades;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          mem_wmem, mem_exc, mem_advance, flush;
  logic [3:0]    mem_load_type, mem_byte_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok, mem_stall;
  logic [3:0]    data_be;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata, load_result;
  state_e        dbg_state;

  mem_access_unit #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_wmem       (mem_wmem),
    .mem_load_type  (mem_load_type),
    .mem_byte_valid (mem_byte_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_exc        (mem_exc),
    .mem_advance    (mem_advance),
    .flush          (flush),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_be        (data_be),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .mem_stall      (mem_stall),
`ifdef MEM_ALIGN_CHECK_EN
    .adel           (adel),
    .ades           (ades),
`endif
    .load_result    (load_result),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t          exp_req_q[$];   // bus requests still to be accepted
  logic [DW-1:0] exp_q[$];       // load_result at retire, one per instruction
  int            exp_stall_q[$]; // stall cycles per instruction
  req_t          head_req;
  int            tests = 0;
  int            fails = 0;
  int            stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension: shift the word down to the addressed lane, then extend.
  function automatic logic [31:0] ext_model(input logic [3:0] ld, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] hw;
    b  = w >> (8 * a);
    hw = w >> (16 * a[1]);
    case (ld)
      LD_LB:   return {{24{b[7]}}, b[7:0]};
      LD_LBU:  return {24'd0, b[7:0]};
      LD_LH:   return {{16{hw[15]}}, hw[15:0]};
      LD_LHU:  return {16'd0, hw[15:0]};
      LD_LW:   return w;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_req_q.delete();
      exp_q.delete();
      exp_stall_q.delete();
      stall_cnt = 0;
    end else begin
      if (mem_stall) stall_cnt++;
      if (data_req && exp_req_q.size() == 0) begin
        check("unexpected_req", data_req, 1'b0);
      end else if ((data_req || data_addr_ok) && exp_req_q.size() != 0) begin
        head_req = exp_req_q[0];
        check("req_valid", data_req, 1'b1);
        check("req_wr", data_wr, head_req.wr);
        check("req_be", data_be, head_req.be);
        check("req_addr", data_addr, head_req.addr);
        if (head_req.wr) check("req_wdata", data_wdata, head_req.wdata);
        if (data_addr_ok) void'(exp_req_q.pop_front());
      end
      if (data_data_ok && exp_q.size() != 0) check("data_ok_result", load_result, exp_q[0]);
      if (mem_advance) begin
        if (exp_q.size() == 0 || exp_stall_q.size() == 0) begin
          check("retire_without_op", exp_q.size(), 1);
        end else begin
          check("retire_result", load_result, exp_q.pop_front());
          check("stall_cycles", stall_cnt, exp_stall_q.pop_front());
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bubble();
    mem_wmem       = 1'b0;
    mem_load_type  = LD_NONE;
    mem_byte_valid = 4'd0;
    mem_exc        = 1'b0;
  endtask

  // One instruction: bus accepts after a cycles, responds d cycles later, and
  // EXE/MEM is held h extra cycles after the response by another stall source.
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic exc,
                       input int a, input int d, input int h);
    logic [3:0]  ld;
    logic        wm;
    logic [3:0]  be;
    int          size;
    logic        mis;
    logic        acc;
    logic [31:0] exp_res;
    ld = LD_NONE; wm = 1'b0; be = 4'd0; size = 0;
    case (kind)
      K_LB:  begin ld = LD_LB;  size = 1; end
      K_LBU: begin ld = LD_LBU; size = 1; end
      K_LH:  begin ld = LD_LH;  size = 2; end
      K_LHU: begin ld = LD_LHU; size = 2; end
      K_LW:  begin ld = LD_LW;  size = 4; end
      K_SB:  begin wm = 1'b1; size = 1; be = 4'b0001 << addr[1:0]; end
      K_SH:  begin wm = 1'b1; size = 2; be = addr[1] ? 4'b1100 : 4'b0011; end
      K_SW:  begin wm = 1'b1; size = 4; be = 4'b1111; end
      default: ;
    endcase
    mis = ALIGN && ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00));
    acc = (wm || ld != LD_NONE) && !exc && !mis;
    exp_res = (acc && ld != LD_NONE) ? ext_model(ld, addr[1:0], rdata) : 32'd0;
    if (acc) exp_req_q.push_back({wm, wm ? be : 4'b1111, {addr[31:2], 2'b00}, wdata});
    exp_q.push_back(exp_res);
    exp_stall_q.push_back(acc ? a + d : 0);

    mem_wmem = wm; mem_load_type = ld; mem_byte_valid = be;
    mem_addr = addr; mem_wdata = wdata; mem_exc = exc;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    check("adel", adel, mis && ld != LD_NONE && !exc);
    check("ades", ades, mis && wm && !exc);
`endif
    if (!acc) begin
      mem_advance = 1'b1;
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c <= a + d + h; c++) begin
        data_addr_ok = (c == a);
        data_data_ok = (c == a + d);
        data_rdata   = data_data_ok ? rdata : $urandom;
        mem_advance  = (c == a + d + h);
        @(posedge clk); #1;
      end
    end
    mem_advance = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    set_bubble();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    logic [31:0] addr;
    rst = 1'b1; set_bubble();
    mem_addr = '0; mem_wdata = '0; mem_advance = 1'b0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", data_req, 1'b0);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_result", load_result, 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(K_LW,  32'h80001004, 32'h0,        32'hDEADBEEF, 1'b0, 0, 3, 0);
    do_op(K_LB,  32'h80001003, 32'h0,        32'h80FF1234, 1'b0, 0, 0, 0);
    do_op(K_SW,  32'h80002000, 32'h12345678, 32'h0,        1'b0, 2, 1, 0);
    do_op(K_LHU, 32'h80003002, 32'h0,        32'hBEEF1234, 1'b0, 1, 1, 3);
    do_op(K_LW,  32'h80003008, 32'h0,        32'h11111111, 1'b1, 0, 0, 0);
    do_op(K_LW,  32'h80004002, 32'h0,        32'h76543210, 1'b0, 0, 1, 0);
    do_op(K_SH,  32'h80004001, 32'hABCD0000, 32'h0,        1'b0, 1, 0, 1);

    // Flush while waiting for the response: the response must be drained.
    exp_req_q.push_back({1'b0, 4'b1111, 32'h80005008, 32'h0});
    exp_q.push_back(32'd0); exp_stall_q.push_back(1);
    exp_q.push_back(32'd0); exp_stall_q.push_back(2);
    mem_load_type = LD_LW; mem_addr = 32'h8000500A; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1; mem_advance = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mem_advance = 1'b0; set_bubble();
    #1;
    check("drain_state", dbg_state, ST_DRAIN);
    check("drain_stall", mem_stall, 1'b1);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    check("drain_exit", dbg_state, ST_IDLE);
    mem_advance = 1'b1;
    @(posedge clk); #1;
    mem_advance = 1'b0;

    // Reset while a load waits for its response.
    exp_req_q.push_back({1'b0, 4'b1111, 32'h80006000, 32'h0});
    mem_load_type = LD_LW; mem_addr = 32'h80006000; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; set_bubble();
    rst = 1'b1;
    #1;
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 8);
      addr = $urandom;
      do_op(kind, addr, $urandom, $urandom, ($urandom_range(0, 7) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queues_empty", exp_q.size() + exp_req_q.size() + exp_stall_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
